// File: rtl/program_loader_if.sv
// Handshake and instruction-memory write bus between the byte-stream source and the loader.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  Start;
  logic                  InValid;
  logic [7:0]            InData;
  logic                  InReady;
  logic                  IMemWriteEnable;
  logic [ADDR_WIDTH-1:0] IMemWriteAddress;
  logic [15:0]           IMemWriteData;
  logic                  CpuReset;
  logic                  Busy;
  logic                  Done;
  logic                  Error;

  modport master (
    output Start, InValid, InData,
    input  InReady, IMemWriteEnable, IMemWriteAddress, IMemWriteData,
    input  CpuReset, Busy, Done, Error
  );

  modport slave (
    input  Start, InValid, InData,
    output InReady, IMemWriteEnable, IMemWriteAddress, IMemWriteData,
    output CpuReset, Busy, Done, Error
  );
endinterface

// File: rtl/program_loader.sv
// Byte-serial instruction-memory loader: parses a count/words/checksum frame, writes
// 16-bit words from address 0 and holds the CPU in reset until a load checks out.
module program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input logic             CLK,
  input logic             RESET,
  program_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHECK, DONE, ERROR} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]            hi_q, hi_d;
  logic [7:0]            xor_q, xor_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  in_ready;
  logic                  xfer;

  assign in_ready = (state_q == COUNT) || (state_q == HI) ||
                    (state_q == LO)    || (state_q == CHECK);
  assign xfer     = bus.InValid && in_ready;

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      ptr_q       <= '0;
      hi_q        <= '0;
      xor_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      ptr_q       <= ptr_d;
      hi_q        <= hi_d;
      xor_q       <= xor_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    ptr_d       = ptr_q;
    hi_d        = hi_q;
    xor_d       = xor_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (bus.Start) begin
          state_d = COUNT;
          ptr_d   = '0;
          xor_d   = '0;
        end
      end
      COUNT: begin
        if (xfer) begin
          // A zero count byte stands for a full memory image.
          remaining_d = (bus.InData == 8'd0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                             : (ADDR_WIDTH+1)'(bus.InData);
          xor_d       = xor_q ^ bus.InData;
          state_d     = HI;
        end
      end
      HI: begin
        if (xfer) begin
          hi_d    = bus.InData;
          xor_d   = xor_q ^ bus.InData;
          state_d = LO;
        end
      end
      LO: begin
        if (xfer) begin
          we_d        = 1'b1;
          waddr_d     = ptr_q;
          wdata_d     = {hi_q, bus.InData};
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
          xor_d       = xor_q ^ bus.InData;
          state_d     = (remaining_q == (ADDR_WIDTH+1)'(1)) ? CHECK : HI;
        end
      end
      CHECK: begin
        if (xfer) state_d = ((xor_q ^ bus.InData) == 8'd0) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.InReady          = in_ready;
  assign bus.Busy             = in_ready;
  assign bus.Done             = (state_q == DONE);
  assign bus.Error            = (state_q == ERROR);
  assign bus.CpuReset         = (state_q != DONE);
  assign bus.IMemWriteEnable  = we_q;
  assign bus.IMemWriteAddress = waddr_q;
  assign bus.IMemWriteData    = wdata_q;
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frames are expanded into expected writes and
// final status by a frame-level model; a monitor pops and compares each write strobe.
module tb_program_loader;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  logic CLK;
  logic RESET;

  program_loader_if #(.ADDR_WIDTH(AW)) bif ();
  program_loader #(.ADDR_WIDTH(AW)) dut (.CLK(CLK), .RESET(RESET), .bus(bif));

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  int  busy_cnt = 0;
  int  valid_mode = 0;
  bit  start_noise = 0;
  int  cyc = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge CLK) begin
    if (bif.Busy === 1'b1) busy_cnt++;
    if (bif.IMemWriteEnable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 bif.IMemWriteAddress, bif.IMemWriteData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(bif.IMemWriteAddress), 32'(e.addr));
        check("write_data", 32'(bif.IMemWriteData), 32'(e.data));
      end
    end
  end

  function automatic logic want_valid();
    case (valid_mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Entered and left at a negedge; returns once the byte has been accepted.
  task automatic drive_byte(input logic [7:0] b);
    int  guard;
    logic acc;
    guard = 0;
    forever begin
      bif.InValid = want_valid();
      bif.InData  = bif.InValid ? b : 8'($urandom);
      bif.Start   = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      acc = bif.InValid && bif.InReady;
      @(negedge CLK);
      cyc++;
      if (acc) break;
      guard++;
      if (guard > 100) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: got no acceptance of %0h, expected within 100 cycles", b);
        break;
      end
    end
    bif.Start = 1'b0;
  endtask

  task automatic do_start();
    bif.Start = 1'b1;
    @(negedge CLK);
    bif.Start = 1'b0;
    check("start_ready", 32'(bif.InReady), 32'd1);
    check("start_cpureset", 32'(bif.CpuReset), 32'd1);
    check("start_done", 32'(bif.Done), 32'd0);
    check("start_error", 32'(bif.Error), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bif.InReady), 32'd0);
    check({tag, "_we"}, 32'(bif.IMemWriteEnable), 32'd0);
    check({tag, "_addr"}, 32'(bif.IMemWriteAddress), 32'd0);
    check({tag, "_data"}, 32'(bif.IMemWriteData), 32'd0);
    check({tag, "_cpureset"}, 32'(bif.CpuReset), 32'd1);
    check({tag, "_busy"}, 32'(bif.Busy), 32'd0);
    check({tag, "_done"}, 32'(bif.Done), 32'd0);
    check({tag, "_error"}, 32'(bif.Error), 32'd0);
  endtask

  function automatic int frame_words(input logic [7:0] cnt);
    return (cnt == 8'd0) ? DEPTH : int'(cnt);
  endfunction

  // Full frame: expected writes and status come from the frame contents alone.
  task automatic run_frame(input logic [7:0] fr[$], input int mode, input bit noise);
    int         n;
    logic [7:0] x;
    n = frame_words(fr[0]);
    x = 8'd0;
    for (int i = 0; i < n; i++)
      exp_q.push_back('{addr: AW'(i), data: {fr[1+2*i], fr[2+2*i]}});
    foreach (fr[i]) x ^= fr[i];
    valid_mode  = mode;
    start_noise = noise;
    if (mode != 0) begin
      bif.InValid = 1'b1;
      bif.InData  = 8'($urandom);
      @(negedge CLK);
      bif.InValid = 1'b0;
    end
    busy_cnt = 0;
    do_start();
    foreach (fr[i]) drive_byte(fr[i]);
    bif.InValid = 1'b0;
    start_noise = 0;
    check("final_done", 32'(bif.Done), 32'(x == 8'd0));
    check("final_error", 32'(bif.Error), 32'(x != 8'd0));
    check("final_cpureset", 32'(bif.CpuReset), 32'(x != 8'd0));
    check("final_busy", 32'(bif.Busy), 32'd0);
    check("final_ready", 32'(bif.InReady), 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    if (mode == 0) check("busy_cycles", 32'(busy_cnt), 32'(2 * n + 2));
  endtask

  // Frame cut short by RESET on the edge that would accept byte 'cut'.
  task automatic run_cut(input logic [7:0] fr[$], input int cut);
    int n;
    n = frame_words(fr[0]);
    for (int i = 0; i < n && (2 + 2 * i) < cut; i++)
      exp_q.push_back('{addr: AW'(i), data: {fr[1+2*i], fr[2+2*i]}});
    valid_mode  = 0;
    start_noise = 0;
    do_start();
    for (int i = 0; i < cut; i++) drive_byte(fr[i]);
    bif.InValid = 1'b1;
    bif.InData  = fr[cut];
    RESET       = 1'b1;
    @(negedge CLK);
    RESET       = 1'b0;
    bif.InValid = 1'b0;
    check_reset_outputs("cut");
    check("cut_pending_writes", 32'(exp_q.size()), 32'd0);
    @(negedge CLK);
    check("cut_no_late_write", 32'(bif.IMemWriteEnable), 32'd0);
  endtask

  function automatic void make_frame(output logic [7:0] fr[$], input int n, input bit good);
    logic [7:0] x;
    fr.delete();
    fr.push_back(8'(n));
    x = 8'(n);
    for (int i = 0; i < 2 * n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      fr.push_back(b);
      x ^= b;
    end
    fr.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
  endfunction

  initial begin
    logic [7:0] fr[$];
    logic [7:0] x;

    RESET       = 1'b1;
    bif.Start   = 1'b0;
    bif.InValid = 1'b0;
    bif.InData  = 8'd0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("por");
    RESET = 1'b0;
    @(negedge CLK);

    // Good load, then the same load again from DONE (Start re-enters COUNT).
    fr = '{8'h02, 8'h12, 8'h34, 8'hA0, 8'h05, 8'h81};
    run_frame(fr, 0, 0);
    run_frame(fr, 0, 0);

    // Bad checksum: writes still land, CPU stays in reset.
    fr = '{8'h02, 8'h12, 8'h34, 8'hA0, 8'h05, 8'h00};
    run_frame(fr, 0, 0);

    // Backpressure (valid every third cycle) and stray Start pulses mid-frame.
    fr = '{8'h02, 8'h12, 8'h34, 8'hA0, 8'h05, 8'h81};
    run_frame(fr, 1, 0);
    run_frame(fr, 0, 1);

    // Full depth: count 00, word i = {i, ~i}.
    fr.delete();
    fr.push_back(8'h00);
    x = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      fr.push_back(8'(i));
      fr.push_back(~8'(i));
      x ^= 8'(i) ^ ~8'(i);
    end
    fr.push_back(x);
    run_frame(fr, 0, 0);

    // Reset on the A0 (HI) edge and on the 05 (LO) edge, then a clean load.
    fr = '{8'h02, 8'h12, 8'h34, 8'hA0, 8'h05, 8'h81};
    run_cut(fr, 3);
    run_cut(fr, 4);
    run_frame(fr, 0, 0);

    for (int t = 0; t < 25; t++) begin
      make_frame(fr, $urandom_range(1, 10), $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0)
        run_cut(fr, $urandom_range(0, fr.size() - 1));
      else
        run_frame(fr, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Byte-serial loader that writes the 16-bit-wide instruction memory the CPU fetches from. It accepts a framed byte stream over a valid/ready handshake: count byte, instruction bytes, checksum byte. It assembles 16-bit instruction words and issues single-cycle writes at sequential addresses from 0. It holds the CPU in reset from system reset until a load completes with a good checksum.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction memory address width; the count byte covers up to 2^ADDR_WIDTH words.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- Start  in  1  begins a load session. Honoured only in IDLE, DONE or ERROR; ignored in every other state.
- InValid  in  1  InData carries a byte.
- InData  in  8  stream byte.
- InReady  out  1  loader accepts a byte this cycle. Decoded from state only, never from InValid.
- IMemWriteEnable  out  1  one-cycle write strobe to instruction memory.
- IMemWriteAddress  out  ADDR_WIDTH  write address.
- IMemWriteData  out  16  instruction word, {high byte, low byte}.
- CpuReset  out  1  drives the CPU RESET input.
- Busy  out  1  high in COUNT, HI, LO and CHECK.
- Done  out  1  last load succeeded.
- Error  out  1  last load failed its checksum.

## Operation
- Handshake: a byte transfers only on a rising edge where InValid & InReady. InValid without InReady has no effect. Stalls of any length are allowed.
- Frame: the count byte N comes first. N=0 means 2^ADDR_WIDTH words. Then 2N instruction bytes, high byte first. Then one checksum byte C.
  - Checksum rule: the XOR of N, all instruction bytes and C must equal 0x00.
- Internal state:
  - remaining counter, ADDR_WIDTH+1 bits.
  - write pointer, ADDR_WIDTH bits, wraps from all-ones to 0.
  - hi-byte register.
  - running XOR, 8 bits.
- States and transitions:
  - IDLE: InReady=0. On Start, go to COUNT. Clear the pointer, the XOR, Done and Error. CpuReset=1.
  - COUNT: InReady=1. On transfer, remaining = (InData==0) ? 2^ADDR_WIDTH : InData. XOR ^= InData. Go to HI.
  - HI: InReady=1. On transfer, latch the hi byte. XOR ^= InData. Go to LO.
  - LO: InReady=1. On transfer:
    - Register address = pointer and data = {hi, InData}. Assert IMemWriteEnable for the next cycle.
    - Increment the pointer. Decrement remaining. XOR ^= InData.
    - Go to CHECK if remaining was 1, else go to HI.
  - CHECK: InReady=1. On transfer, go to DONE if (XOR ^ InData)==0, else go to ERROR.
  - DONE: Done=1, CpuReset=0, InReady=0. On Start, go to COUNT with CpuReset=1 and Done=0.
  - ERROR: Error=1, CpuReset=1, InReady=0. On Start, go to COUNT with Error=0.
- Words already written are not rolled back on ERROR. The CPU stays in reset.
- Start arriving on the same edge as a transfer, in a non-honouring state: Start is ignored and the transfer is processed.

## Timing
- Reset values:
  - State IDLE.
  - InReady 0, IMemWriteEnable 0, IMemWriteAddress 0, IMemWriteData 0.
  - CpuReset 1, Busy 0, Done 0, Error 0.
- RESET dominates Start and transfers on the same edge.
- RESET mid-load returns to IDLE. No write strobe is issued on the following cycle, even if a LO transfer coincided with RESET.
- Start sampled at edge k gives COUNT and InReady=1 from cycle k+1.
- Throughput is at most one byte per cycle. A frame with continuous InValid takes 2N+2 cycles in Busy.
- IMemWriteEnable is high exactly one cycle: the cycle after each LO transfer. Address and data are stable during that cycle.
- Done or Error and CpuReset take their final values the cycle after the CHECK transfer.
- Outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Test plan
- Good load: Start, then bytes 02, 12, 34, A0, 05, 81 with continuous valid.
  - Writes: addr 00 = 1234, addr 01 = A005.
  - Then Done=1, Error=0, CpuReset=0, Busy=0.
- Bad checksum: same frame with final byte 00.
  - The same two writes occur.
  - Then Error=1, Done=0, CpuReset stays 1.
- Backpressure: the good-load frame with InValid high only on every third cycle.
  - Identical two writes, no duplicated or extra strobes.
  - Bytes presented while InReady=0 are ignored.
- Full depth: N=00 followed by 512 bytes where word i = {i, ~i}, plus the correct checksum.
  - 256 writes; the last is addr FF = FF00.
  - Then Done=1.
- Reset mid-load: Start, then 02, 12, 34, A0, with RESET asserted on the edge of the A0 transfer.
  - No write for A0. All outputs return to reset values.
  - A following good load completes normally from addr 00.
- Start handling:
  - Start asserted while in HI is ignored; the frame completes unchanged.
  - Start in DONE reasserts CpuReset and enters COUNT on the next cycle.
